vec_mem_ctrl: RTL and testbench
===============================

VEC_MEM_CTRL -- requirements
Module: vec_mem_ctrl

Interface
REQ-001 Parameters SHALL be: VLEN, 8, elements per vector; DW, 16, element data width; AW, 8, memory address width.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request from the instruction decoder to begin a vector memory operation.
REQ-005 rw  input  1  0 = load (memory to vector register), 1 = store (vector register to memory).
REQ-006 stride_enable  input  1  1 = strided addressing using the stride input.
REQ-007 mask_enable  input  1  1 = element-masked access using the mask input.
REQ-008 vx_select  input  3  target/source vector register number.
REQ-009 base  input  AW  scalar base address (value of register rx).
REQ-010 stride  input  AW  scalar stride (value of register ry).
REQ-011 mask  input  VLEN  element mask; bit i enables element i.
REQ-012 vrf_sel  output  3  vector register number presented to the vector register file.
REQ-013 vrf_idx  output  3  element index presented to the vector register file.
REQ-014 vrf_we  output  1  vector register file element write enable.
REQ-015 vrf_wdata  output  DW  element write data (load path).
REQ-016 vrf_rdata  input  DW  element read data for vrf_sel/vrf_idx, combinational (store path).
REQ-017 mem_req / mem_we / mem_addr / mem_wdata  output  1/1/AW/DW  data memory request, write strobe, address, write data.
REQ-018 mem_rdata / mem_ack  input  DW/1  data memory read data and acknowledge.
REQ-019 done  output  1  one-cycle completion pulse back to the decoder.
REQ-020 busy  output  1  high from the cycle after an accepted start through the done cycle.

Function
REQ-021 FSM SHALL have states IDLE, ACCESS, FIN; encoding from the shared package.
REQ-022 IDLE: on start=1, latch rw, stride_enable, mask_enable, vx_select, base, stride, mask; set idx=0, addr=base; go to ACCESS next cycle.
REQ-023 ACCESS, element idx enabled (mask_enable=0 or mask[idx]=1): mem_req=1, mem_addr=addr, mem_we=rw, mem_wdata=vrf_rdata; hold all until mem_ack=1.
REQ-024 Load: in the cycle mem_ack=1, vrf_we=1 and vrf_wdata=mem_rdata for vrf_sel/vrf_idx=idx; vrf_we SHALL be 0 at all other times.
REQ-025 Element completion (ack, or element masked off) SHALL advance idx by 1 and addr by step in the same cycle; masked-off element: no mem_req, no vrf_we, exactly one cycle.
REQ-026 step SHALL be stride when stride_enable=1, else 1; addr arithmetic modulo 2^AW (wrap 8'hFF+1 = 8'h00); stride=0 repeats the same address.
REQ-027 Completion of element VLEN-1 SHALL go to FIN; FIN drives done=1 for exactly one cycle, then IDLE.
REQ-028 With mem_ack tied high, latency start-sample to done SHALL be VLEN+1 cycles; mask=0 with mask_enable=1 gives the same latency with zero memory requests.
REQ-029 start SHALL be ignored while in ACCESS or FIN; start coincident with done in FIN is not accepted.
REQ-030 Latched operands SHALL be stable for the whole operation regardless of input changes after start.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE, idx=0, addr=0, and all outputs 0 (done, busy, mem_req, mem_we, vrf_we, data/address buses).
REQ-032 Reset mid-operation SHALL abort with no done pulse; outstanding mem_req drops immediately.

Structure
REQ-033 Package vec_pkg SHALL hold VLEN, DW, AW, FSM state typedef, and load/store opcode constants shared with the decoder.
REQ-034 Address stepping SHALL live in one sub-module vec_addr_gen (load base, advance by step, wrap).

Verification
REQ-035 Unit load: base=8'h10, ack tied high, mem_rdata=addr -> 8 writes idx0..7 data 10..17, done at cycle 9.
REQ-036 Strided store: base=8'hF0, stride=8'h04 -> mem_addr F0,F4,F8,FC,00,04,08,0C, mem_we=1, wdata=vrf_rdata.
REQ-037 Masked load: mask=8'b1010_0101 -> requests only for idx 0,2,5,7; vrf_we 4 times; done at cycle 9.
REQ-038 Ack stall: mem_ack low 3 cycles on element 2 -> mem_addr/mem_req held; done delayed by 3 cycles.
REQ-039 Reset at element 4 -> outputs 0 immediately, no done; new start afterwards completes normally; start during busy ignored.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants, FSM encoding and latched-operand payload for the vector memory controller.
// Opcode constants are shared with the instruction decoder.
package vec_pkg;

    localparam int unsigned VLEN = 8;
    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 8;
    localparam int unsigned IW   = $clog2(VLEN);
    localparam int unsigned RW   = 3;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_FIN    = 2'd2
    } state_t;

    // Operands captured on an accepted start; base lives in the address generator.
    typedef struct packed {
        logic            rw;
        logic            stride_enable;
        logic            mask_enable;
        logic [RW-1:0]   vx_select;
        logic [AW-1:0]   stride;
        logic [VLEN-1:0] mask;
    } op_t;

    function automatic logic elem_enabled(input logic            mask_enable,
                                          input logic [VLEN-1:0] mask,
                                          input logic [IW-1:0]   idx);
        return !mask_enable || mask[idx];
    endfunction

endpackage

// File: rtl/vec_mem_ctrl_if.sv
// Decoder command, vector register file port and data memory port of the vector memory controller.
// master = controller side, slave = decoder/VRF/memory side.
interface vec_mem_ctrl_if;
    import vec_pkg::*;

    logic            start;
    logic            rw;
    logic            stride_enable;
    logic            mask_enable;
    logic [RW-1:0]   vx_select;
    logic [AW-1:0]   base;
    logic [AW-1:0]   stride;
    logic [VLEN-1:0] mask;

    logic [RW-1:0]   vrf_sel;
    logic [IW-1:0]   vrf_idx;
    logic            vrf_we;
    logic [DW-1:0]   vrf_wdata;
    logic [DW-1:0]   vrf_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;

    logic            done;
    logic            busy;

    modport master (
        input  start, rw, stride_enable, mask_enable, vx_select, base, stride, mask,
        input  vrf_rdata, mem_rdata, mem_ack,
        output vrf_sel, vrf_idx, vrf_we, vrf_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output done, busy
    );

    modport slave (
        output start, rw, stride_enable, mask_enable, vx_select, base, stride, mask,
        output vrf_rdata, mem_rdata, mem_ack,
        input  vrf_sel, vrf_idx, vrf_we, vrf_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  done, busy
    );

endinterface

// File: rtl/vec_addr_gen.sv
// Element address register: loads the base, advances by step per completed element,
// wrapping modulo 2^AW.
module vec_addr_gen
    import vec_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_addr,
    input  logic          advance,
    input  logic [AW-1:0] step,
    output logic [AW-1:0] addr
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_addr;
        end else if (advance) begin
            addr <= addr + step;
        end
    end

endmodule

// File: rtl/vec_mem_ctrl.sv
// Vector load/store sequencer: walks VLEN elements of one vector register, issuing one
// data memory access per enabled element, with unit/strided addressing and element masking.
module vec_mem_ctrl
    import vec_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    vec_mem_ctrl_if.master bus
);

    state_t        state, state_nx;
    op_t           op_q, op_nx;
    logic [IW-1:0] idx, idx_nx;
    logic          mem_req_q, mem_req_nx;
    logic          mem_we_q, mem_we_nx;
    logic          done_q, done_nx;
    logic          busy_q, busy_nx;
    logic          accept;
    logic          cur_en;
    logic          elem_done;
    logic [AW-1:0] addr;
    logic [AW-1:0] step;

    assign accept    = (state == ST_IDLE) && bus.start;
    assign cur_en    = elem_enabled(op_q.mask_enable, op_q.mask, idx);
    // A masked-off element retires in one cycle without touching memory.
    assign elem_done = (state == ST_ACCESS) && (!cur_en || bus.mem_ack);
    assign step      = op_q.stride_enable ? op_q.stride : AW'(1);

    vec_addr_gen u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .load_addr (bus.base),
        .advance   (elem_done),
        .step      (step),
        .addr      (addr)
    );

    // Next-state, operand capture and next values of the registered outputs.
    always_comb begin
        state_nx = state;
        op_nx    = op_q;
        idx_nx   = idx;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    op_nx = '{rw:            bus.rw,
                              stride_enable: bus.stride_enable,
                              mask_enable:   bus.mask_enable,
                              vx_select:     bus.vx_select,
                              stride:        bus.stride,
                              mask:          bus.mask};
                    idx_nx   = '0;
                    state_nx = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (elem_done) begin
                    idx_nx = idx + IW'(1);
                    if (idx == IW'(VLEN - 1)) begin
                        state_nx = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        mem_req_nx = (state_nx == ST_ACCESS) &&
                     elem_enabled(op_nx.mask_enable, op_nx.mask, idx_nx);
        mem_we_nx  = mem_req_nx && (op_nx.rw == OP_STORE);
        done_nx    = (state_nx == ST_FIN);
        busy_nx    = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            idx       <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            op_q      <= op_nx;
            idx       <= idx_nx;
            mem_req_q <= mem_req_nx;
            mem_we_q  <= mem_we_nx;
            done_q    <= done_nx;
            busy_q    <= busy_nx;
        end
    end

    // Data paths pass straight through in the acknowledge / request cycle and read 0 otherwise.
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = mem_we_q ? bus.vrf_rdata : '0;
    assign bus.vrf_sel   = op_q.vx_select;
    assign bus.vrf_idx   = idx;
    assign bus.vrf_we    = mem_req_q && !mem_we_q && bus.mem_ack;
    assign bus.vrf_wdata = bus.vrf_we ? bus.mem_rdata : '0;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vec_mem_ctrl.sv
// Self-checking bench for vec_mem_ctrl: table of operations with a memory/VRF scoreboard,
// plus hand-written ack-stall, start-while-busy, start-at-done and mid-operation reset sequences.
module tb_vec_mem_ctrl;
    import vec_pkg::*;

    typedef struct {
        logic       rw;
        logic       stride_en;
        logic       mask_en;
        logic [2:0] sel;
        logic [7:0] base;
        logic [7:0] stride;
        logic [7:0] mask;
        logic [7:0] rdata_hi;
        int         exp_nreq;
        int         exp_nvwe;
        int         exp_lat;
        bit         stall;
        bit         start_busy;
        bit         start_at_done;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic        we;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic [2:0]  sel;
        logic [2:0]  idx;
        logic [15:0] data;
    } vrf_exp_t;

    logic clk;
    logic reset;
    logic [7:0] rdata_hi;
    logic stall_en;
    int   stall_cnt;

    int n_cmp;
    int n_fail;
    int n_req_seen;
    int n_vwe_seen;

    mem_exp_t mem_q[$];
    vrf_exp_t vrf_q[$];
    vec_t     vecs[9];

    vec_mem_ctrl_if bus();

    vec_mem_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [15:0] vrf_model(input logic [2:0] sel, input logic [2:0] idx);
        return {4'hB, 1'b0, sel, 5'b00000, idx};
    endfunction

    // Environment: VRF read port, memory returning {rdata_hi, addr}, optional 3-cycle stall on element 2.
    assign bus.vrf_rdata = vrf_model(bus.vrf_sel, bus.vrf_idx);
    assign bus.mem_rdata = {rdata_hi, bus.mem_addr};
    assign bus.mem_ack   = !(stall_en && bus.mem_req && (bus.vrf_idx == 3'd2) && (stall_cnt < 3));

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= 0;
        end else if (!bus.busy) begin
            stall_cnt <= 0;
        end else if (stall_en && bus.mem_req && (bus.vrf_idx == 3'd2) && (stall_cnt < 3)) begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every memory handshake and every VRF write is popped and compared.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.mem_req && bus.mem_ack) begin
                n_req_seen++;
                if (mem_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr %0h expected no request", bus.mem_addr);
                end else begin
                    mem_exp_t e;
                    e = mem_q.pop_front();
                    check("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("mem_we", 32'(bus.mem_we), 32'(e.we));
                    if (e.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                end
            end
            if (bus.vrf_we) begin
                n_vwe_seen++;
                if (vrf_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_vrf_we: got idx %0d expected no write", bus.vrf_idx);
                end else begin
                    vrf_exp_t r;
                    r = vrf_q.pop_front();
                    check("vrf_sel", 32'(bus.vrf_sel), 32'(r.sel));
                    check("vrf_idx", 32'(bus.vrf_idx), 32'(r.idx));
                    check("vrf_wdata", 32'(bus.vrf_wdata), 32'(r.data));
                end
            end
        end
    end

    task automatic push_expect(input vec_t v);
        logic [7:0] a;
        logic [7:0] st;
        a  = v.base;
        st = v.stride_en ? v.stride : 8'd1;
        for (int i = 0; i < 8; i++) begin
            if (!v.mask_en || v.mask[i]) begin
                mem_exp_t m;
                m.addr  = a;
                m.we    = v.rw;
                m.wdata = vrf_model(v.sel, 3'(i));
                mem_q.push_back(m);
                if (!v.rw) begin
                    vrf_exp_t r;
                    r.sel  = v.sel;
                    r.idx  = 3'(i);
                    r.data = {v.rdata_hi, a};
                    vrf_q.push_back(r);
                end
            end
            a = a + st;
        end
    endtask

    task automatic scramble();
        bus.rw            = 1'($urandom);
        bus.stride_enable = 1'($urandom);
        bus.mask_enable   = 1'($urandom);
        bus.vx_select     = 3'($urandom);
        bus.base          = 8'($urandom);
        bus.stride        = 8'($urandom);
        bus.mask          = 8'($urandom);
    endtask

    task automatic drive_start(input vec_t v);
        @(posedge clk); #1;
        bus.start         = 1'b1;
        bus.rw            = v.rw;
        bus.stride_enable = v.stride_en;
        bus.mask_enable   = v.mask_en;
        bus.vx_select     = v.sel;
        bus.base          = v.base;
        bus.stride        = v.stride;
        bus.mask          = v.mask;
        rdata_hi          = v.rdata_hi;
        stall_en          = v.stall;
        push_expect(v);
        n_req_seen = 0;
        n_vwe_seen = 0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
    endtask

    task automatic run_op(input vec_t v, input int id);
        int cyc;
        bit seen_done;
        check("busy_before_start", 32'(bus.busy), 32'd0);
        drive_start(v);
        cyc       = 0;
        seen_done = 0;
        while (!seen_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_after_start", 32'(bus.busy), 32'd1);
            if (v.stall && cyc >= 3 && cyc <= 6) begin
                check("stall_req_held", 32'(bus.mem_req), 32'd1);
                check("stall_addr_held", 32'(bus.mem_addr), 32'(8'(v.base + 8'd2)));
            end
            if (v.start_busy && cyc == 3) bus.start = 1'b1;
            if (v.start_busy && cyc == 4) bus.start = 1'b0;
            if (bus.done) seen_done = 1;
        end
        check($sformatf("latency_op%0d", id), 32'(cyc), 32'(v.exp_lat));
        if (v.start_at_done) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check($sformatf("done_pulse_op%0d", id), 32'(bus.done), 32'd0);
        check($sformatf("busy_clear_op%0d", id), 32'(bus.busy), 32'd0);
        check($sformatf("nreq_op%0d", id), 32'(n_req_seen), 32'(v.exp_nreq));
        check($sformatf("nvwe_op%0d", id), 32'(n_vwe_seen), 32'(v.exp_nvwe));
        check($sformatf("memq_left_op%0d", id), 32'(mem_q.size()), 32'd0);
        check($sformatf("vrfq_left_op%0d", id), 32'(vrf_q.size()), 32'd0);
        mem_q.delete();
        vrf_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_req"},   32'(bus.mem_req),   32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, "_vrf_we"},    32'(bus.vrf_we),    32'd0);
        check({tag, "_vrf_wdata"}, 32'(bus.vrf_wdata), 32'd0);
        check({tag, "_vrf_sel"},   32'(bus.vrf_sel),   32'd0);
        check({tag, "_vrf_idx"},   32'(bus.vrf_idx),   32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    function automatic vec_t mk(input logic rw, input logic se, input logic me, input logic [2:0] sel,
                                input logic [7:0] base, input logic [7:0] stride, input logic [7:0] mask,
                                input logic [7:0] hi, input int nreq, input int nvwe, input int lat,
                                input bit stall, input bit sb, input bit sad);
        vec_t v;
        v.rw = rw; v.stride_en = se; v.mask_en = me; v.sel = sel;
        v.base = base; v.stride = stride; v.mask = mask; v.rdata_hi = hi;
        v.exp_nreq = nreq; v.exp_nvwe = nvwe; v.exp_lat = lat;
        v.stall = stall; v.start_busy = sb; v.start_at_done = sad;
        return v;
    endfunction

    initial begin
        vec_t rv;
        //            rw    se    me    sel   base   stride mask          hi     nreq nvwe lat stall sb sad
        vecs[0] = mk(1'b0, 1'b0, 1'b0, 3'd3, 8'h10, 8'h00, 8'h00,        8'h00, 8,   8,   9,  0,    0, 0);
        vecs[1] = mk(1'b1, 1'b1, 1'b0, 3'd5, 8'hF0, 8'h04, 8'h00,        8'h00, 8,   0,   9,  0,    0, 0);
        vecs[2] = mk(1'b0, 1'b0, 1'b1, 3'd2, 8'h20, 8'h00, 8'b1010_0101, 8'h00, 4,   4,   9,  0,    0, 0);
        vecs[3] = mk(1'b1, 1'b0, 1'b1, 3'd6, 8'h44, 8'h00, 8'h00,        8'h00, 0,   0,   9,  0,    0, 0);
        vecs[4] = mk(1'b0, 1'b1, 1'b0, 3'd1, 8'h7F, 8'h00, 8'h00,        8'h3C, 8,   8,   9,  0,    0, 0);
        vecs[5] = mk(1'b0, 1'b1, 1'b1, 3'd7, 8'hFE, 8'h03, 8'b0110_0011, 8'h5A, 4,   4,   9,  0,    0, 0);
        vecs[6] = mk(1'b1, 1'b0, 1'b0, 3'd4, 8'hFC, 8'h00, 8'h00,        8'h00, 8,   0,   9,  0,    1, 0);
        vecs[7] = mk(1'b1, 1'b1, 1'b1, 3'd0, 8'h33, 8'h10, 8'h80,        8'h00, 1,   0,   9,  0,    0, 1);
        vecs[8] = mk(1'b0, 1'b0, 1'b0, 3'd3, 8'h40, 8'h00, 8'h00,        8'h11, 8,   8,   12, 1,    0, 0);

        n_cmp = 0; n_fail = 0; n_req_seen = 0; n_vwe_seen = 0;
        rdata_hi = 8'h00; stall_en = 1'b0;
        bus.start = 1'b0;
        scramble();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_op(vecs[i], i);

        // Reset while element 4 is being requested aborts without a done pulse.
        rv = mk(1'b0, 1'b0, 1'b0, 3'd1, 8'h60, 8'h00, 8'h00, 8'h00, 8, 8, 9, 0, 0, 0);
        drive_start(rv);
        repeat (5) @(negedge clk);
        check("pre_reset_req", 32'(bus.mem_req), 32'd1);
        check("pre_reset_idx", 32'(bus.vrf_idx), 32'd4);
        check("pre_reset_addr", 32'(bus.mem_addr), 32'h64);
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (3) begin
            @(negedge clk);
            check("no_done_in_reset", 32'(bus.done), 32'd0);
        end
        mem_q.delete();
        vrf_q.delete();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_after_reset", 32'(bus.busy), 32'd0);
        end
        run_op(vecs[0], 9);
        run_op(vecs[6], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
